id_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 93 +++++++++
 rtl/imm_gen.sv | 37 +++
 rtl/id_stage.sv | 155 +++++++++++++++
 tb/tb_id_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I decode definitions.
//   - opcode, funct3 and funct7 constants
//   - ctrl_t: decoded control bundle produced in ID and registered into ID/EX
//   - decode(): opcode-driven control decode (everything except the immediate)
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0] aluop;    // opcode
    logic [2:0] alusel;   // funct3 (0 for formats without one)
    logic [6:0] aluc;     // funct7 (R-type and immediate shifts only)
    logic [4:0] wd;       // rd for formats that write rd, else 0
    logic       wreg;
    logic       wmem;
    logic       rmem;
    logic       illegal;
    logic       rd_rs1;   // instruction reads rs1
    logic       rd_rs2;   // instruction reads rs2
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t c;
    logic  wr;
    c        = '0;
    wr       = 1'b0;
    c.aluop  = inst[6:0];
    case (inst[6:0])
      OP_R: begin
        c.alusel = inst[14:12];
        c.aluc   = inst[31:25];
        c.rd_rs1 = 1'b1;
        c.rd_rs2 = 1'b1;
        wr       = 1'b1;
      end
      OP_IMM: begin
        c.alusel = inst[14:12];
        c.rd_rs1 = 1'b1;
        wr       = 1'b1;
        // shifts carry SRLI/SRAI selection in the funct7 slot
        if (inst[14:12] == F3_SLL || inst[14:12] == F3_SR) c.aluc = inst[31:25];
      end
      OP_LOAD: begin
        c.alusel = inst[14:12];
        c.rd_rs1 = 1'b1;
        c.rmem   = 1'b1;
        wr       = 1'b1;
      end
      OP_STORE: begin
        c.alusel = inst[14:12];
        c.rd_rs1 = 1'b1;
        c.rd_rs2 = 1'b1;
        c.wmem   = 1'b1;
      end
      OP_BRANCH: begin
        c.alusel = inst[14:12];
        c.rd_rs1 = 1'b1;
        c.rd_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: wr = 1'b1;
      OP_JALR: begin
        c.alusel = inst[14:12];
        c.rd_rs1 = 1'b1;
        wr       = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    if (wr) c.wd = inst[11:7];
    c.wreg = wr && (inst[11:7] != 5'd0);
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   inst : instruction word
//   imm  : immediate for the instruction's format, sign-extended to XLEN
//          (shift amounts are zero-extended; unknown opcodes give 0)
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      OP_IMM: begin
        if (inst[14:12] == F3_SLL || inst[14:12] == F3_SR)
          imm32 = {27'b0, inst[24:20]};
        else
          imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:         imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {inst[31:12], 12'b0};
      OP_JAL:           imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:          imm32 = '0;
    endcase
  end

  // signed cast sign-extends when XLEN is wider than 32
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage with operand forwarding and
// load-use / RAW hazard stalling, feeding EX through a valid/ready ID/EX reg.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : fetch handshake, in_pc/in_inst offered word
//   rf_raddr*/rf_rdata*   : regfile read port (data returned same cycle)
//   ex_*/mem_*            : EX and MEM writeback buses used for forwarding
//   flush                 : redirect; squashes both the offer and ID/EX
//   out_valid/out_ready   : EX handshake; out_* are the ID/EX register
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_wreg,
  input  logic [4:0]      ex_wd,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            mem_wreg,
  input  logic [4:0]      mem_wd,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [6:0]      out_aluop,
  output logic [2:0]      out_alusel,
  output logic [6:0]      out_aluc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_wd,
  output logic            out_wreg,
  output logic            out_wmem,
  output logic            out_rmem,
  output logic            out_illegal
);

  ctrl_t           dec;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] imm, src1, src2;
  logic            load_use, raw, hazard, advance, load;

  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;

  always_comb dec = decode(in_inst);

  imm_gen #(.XLEN(XLEN)) u_imm (
    .inst (in_inst),
    .imm  (imm)
  );

  // Youngest producer wins: EX before MEM before the regfile.
  function automatic logic [XLEN-1:0] opnd(
    input logic            rd_en,
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf,
    input logic            exw,
    input logic [4:0]      exd,
    input logic [XLEN-1:0] exv,
    input logic            memw,
    input logic [4:0]      memd,
    input logic [XLEN-1:0] memv
  );
    if (!rd_en || rs == 5'd0) return '0;
    if (FWD_EN) begin
      if (exw && exd == rs)   return exv;
      if (memw && memd == rs) return memv;
    end
    return rf;
  endfunction

  // a read source (never x0) collides with an in-flight writer
  function automatic logic hits(
    input logic       rd_en,
    input logic [4:0] rs,
    input logic       wen,
    input logic [4:0] wd
  );
    return rd_en && (rs != 5'd0) && wen && (wd == rs);
  endfunction

  always_comb begin
    src1 = opnd(dec.rd_rs1, rs1, rf_rdata1, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata);
    src2 = opnd(dec.rd_rs2, rs2, rf_rdata2, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata);
  end

  // Load data only exists once the load reaches MEM, so a consumer directly
  // behind a load waits one cycle and then picks it off the MEM bus.
  assign load_use = hits(dec.rd_rs1, rs1, out_valid && out_rmem, out_wd)
                 || hits(dec.rd_rs2, rs2, out_valid && out_rmem, out_wd);

  // Without forwarding, wait until no stage ahead still owes the register.
  assign raw = hits(dec.rd_rs1, rs1, out_valid && out_wreg, out_wd)
            || hits(dec.rd_rs1, rs1, ex_wreg, ex_wd)
            || hits(dec.rd_rs1, rs1, mem_wreg, mem_wd)
            || hits(dec.rd_rs2, rs2, out_valid && out_wreg, out_wd)
            || hits(dec.rd_rs2, rs2, ex_wreg, ex_wd)
            || hits(dec.rd_rs2, rs2, mem_wreg, mem_wd);

  assign hazard   = FWD_EN ? load_use : raw;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_aluop   <= '0;
      out_alusel  <= '0;
      out_aluc    <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_wd      <= '0;
      out_wreg    <= 1'b0;
      out_wmem    <= 1'b0;
      out_rmem    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      // squashes a held instruction too, even under backpressure
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= load;
      if (load) begin
        out_pc      <= in_pc;
        out_aluop   <= dec.aluop;
        out_alusel  <= dec.alusel;
        out_aluc    <= dec.aluc;
        out_rs1_val <= src1;
        out_rs2_val <= src2;
        out_imm     <= imm;
        out_wd      <= dec.wd;
        out_wreg    <= dec.wreg;
        out_wmem    <= dec.wmem;
        out_rmem    <= dec.rmem;
        out_illegal <= dec.illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wreg, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;
  logic        out_valid, out_wreg, out_wmem, out_rmem, out_illegal;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [6:0]  out_aluop, out_aluc;
  logic [2:0]  out_alusel;
  logic [4:0]  out_wd;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_aluc(out_aluc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_wmem(out_wmem), .out_rmem(out_rmem), .out_illegal(out_illegal)
  );

  // bench acts as the register file
  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  typedef struct {
    logic [31:0] pc, rs1v, rs2v, imm;
    logic [6:0]  aluop, aluc;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg, wmem, rmem, illegal;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0;

  // reference-model occupancy of the ID/EX register
  bit         mv = 1'b0, m_rmem = 1'b0;
  logic [4:0] m_wd = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] sext(input int v, input int bits);
    int r;
    r = v;
    if (v >= (1 << (bits - 1))) r = v - (1 << bits);
    return r;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (ex_wreg && ex_wd == rs) return ex_wdata;
    if (mem_wreg && mem_wd == rs) return mem_wdata;
    return regs[rs];
  endfunction

  function automatic void ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                  output exp_t e, output bit r1, output bit r2);
    logic [2:0] f3;
    bit wr;
    f3 = i[14:12];
    r1 = 0; r2 = 0; wr = 0;
    e.pc = pc; e.aluop = i[6:0]; e.alusel = 0; e.aluc = 0; e.imm = 0;
    e.wmem = 0; e.rmem = 0; e.illegal = 0;
    case (i[6:0])
      7'h33: begin r1 = 1; r2 = 1; wr = 1; e.alusel = f3; e.aluc = i[31:25]; end
      7'h13: begin
        r1 = 1; wr = 1; e.alusel = f3;
        if (f3 == 1 || f3 == 5) begin e.imm = i[24:20]; e.aluc = i[31:25]; end
        else e.imm = sext(int'(i[31:20]), 12);
      end
      7'h03: begin r1 = 1; wr = 1; e.alusel = f3; e.rmem = 1; e.imm = sext(int'(i[31:20]), 12); end
      7'h23: begin r1 = 1; r2 = 1; e.alusel = f3; e.wmem = 1; e.imm = sext(int'({i[31:25], i[11:7]}), 12); end
      7'h63: begin
        r1 = 1; r2 = 1; e.alusel = f3;
        e.imm = sext(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin wr = 1; e.imm = i & 32'hFFFF_F000; end
      7'h6F: begin
        wr = 1;
        e.imm = sext(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2, 21);
      end
      7'h67: begin r1 = 1; wr = 1; e.alusel = f3; e.imm = sext(int'(i[31:20]), 12); end
      default: e.illegal = 1;
    endcase
    e.wd   = wr ? i[11:7] : 5'd0;
    e.wreg = wr && (i[11:7] != 0);
    e.rs1v = r1 ? opnd(i[19:15]) : 32'd0;
    e.rs2v = r2 ? opnd(i[24:20]) : 32'd0;
  endfunction

  // stimulus-side model: predicts in_ready and pushes accepted instructions
  initial begin
    exp_t e;
    bit r1, r2, haz, adv, rdy;
    forever begin
      @(negedge clk); #1;
      ref_dec(in_inst, in_pc, e, r1, r2);
      haz = mv && m_rmem && m_wd != 0 &&
            ((r1 && in_inst[19:15] == m_wd) || (r2 && in_inst[24:20] == m_wd));
      adv = !mv || out_ready;
      rdy = adv && !haz && !flush;
      if (rst) begin
        mv = 0; m_rmem = 0; m_wd = 0;
        exp_q.delete();
      end else begin
        chk("in_ready", in_ready, rdy);
        chk("rf_raddr1", rf_raddr1, in_inst[19:15]);
        if (flush) begin
          mv = 0;
          exp_q.delete();
        end else if (adv) begin
          mv = in_valid && rdy;
          if (mv) begin
            m_rmem = e.rmem; m_wd = e.wd;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // monitor: compares whatever the ID/EX register presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: out_valid=1 pc=%h expected none", out_pc);
        end else begin
          e = exp_q[0];
          chk("pc", out_pc, e.pc);
          chk("aluop", out_aluop, e.aluop);
          chk("alusel", out_alusel, e.alusel);
          chk("aluc", out_aluc, e.aluc);
          chk("rs1_val", out_rs1_val, e.rs1v);
          chk("rs2_val", out_rs2_val, e.rs2v);
          chk("imm", out_imm, e.imm);
          chk("wd", out_wd, e.wd);
          chk("flags", {out_wreg, out_wmem, out_rmem, out_illegal},
                       {e.wreg, e.wmem, e.rmem, e.illegal});
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        tests++; fails++;
        $display("FAIL missing_out: out_valid=%b expected pc=%h", out_valid, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_rs1"}, out_rs1_val, 0);
    chk({tag, "_ctl"}, {out_aluop, out_alusel, out_aluc, out_wd,
                        out_wreg, out_wmem, out_rmem, out_illegal}, 0);
  endtask

  initial begin
    logic [6:0] ops [11];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h7F};
    foreach (regs[k]) regs[k] = $urandom;
    regs[0] = 0;
    rst = 1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; out_ready = 1;
    ex_wreg = 0; ex_wd = 0; ex_wdata = 0; mem_wreg = 0; mem_wd = 0; mem_wdata = 0;

    repeat (2) cyc();
    @(negedge clk);
    chk_zero("reset");
    cyc(); rst = 0;

    // addi x1,x0,5
    in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h100;
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_wd", {out_wreg, out_wd}, {1'b1, 5'd1});
    chk("addi_rs1", out_rs1_val, 0);

    // add x3,x1,x2: EX beats MEM
    cyc(); in_valid = 1; in_inst = 32'h0020_81B3; in_pc = 32'h104;
    ex_wreg = 1; ex_wd = 1; ex_wdata = 32'h11;
    mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h22;
    cyc(); in_valid = 0; ex_wreg = 0; mem_wreg = 0;
    @(negedge clk);
    chk("fwd_ex_prio", out_rs1_val, 32'h11);

    // lw x5,0(x0); add x6,x5,x5 -> one bubble, then MEM forward
    cyc(); in_valid = 1; in_inst = 32'h0000_0283; in_pc = 32'h108;
    cyc(); in_inst = 32'h0052_8333; in_pc = 32'h10C;
    @(negedge clk);
    chk("loaduse_stall", in_ready, 0);
    cyc(); mem_wreg = 1; mem_wd = 5; mem_wdata = 32'hCAFE;
    @(negedge clk);
    chk("loaduse_bubble", out_valid, 0);
    cyc(); in_valid = 0; mem_wreg = 0;
    @(negedge clk);
    chk("loaduse_rs1", out_rs1_val, 32'hCAFE);
    chk("loaduse_rs2", out_rs2_val, 32'hCAFE);

    // backpressure: 3 held cycles
    cyc(); in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h110;
    cyc(); in_inst = 32'h0070_0113; in_pc = 32'h114; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_ready", in_ready, 0);
      chk("hold_imm", out_imm, 5);
      chk("hold_pc", out_pc, 32'h110);
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_ready", in_ready, 1);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("release_imm", out_imm, 7);

    // flush with a pending load-use hazard
    cyc(); in_valid = 1; in_inst = 32'h0000_0283; in_pc = 32'h118;
    cyc(); in_inst = 32'h0052_8333; in_pc = 32'h11C; flush = 1;
    cyc(); flush = 0; in_inst = 32'h0050_0093; in_pc = 32'h120;
    @(negedge clk);
    chk("flush_bubble", out_valid, 0);
    chk("after_flush_ready", in_ready, 1);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("after_flush_pc", out_pc, 32'h120);

    // beq -4, then an illegal word
    cyc(); in_valid = 1; in_inst = 32'hFE00_0EE3; in_pc = 32'h124;
    cyc(); in_inst = 32'hFFFF_FFFF; in_pc = 32'h128;
    @(negedge clk);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_wreg", out_wreg, 0);
    cyc(); in_valid = 0;
    @(negedge clk);
    chk("illegal", {out_illegal, out_wreg, out_wmem, out_rmem}, 4'b1000);

    // reset mid-stream while stalled with a flush pending
    cyc(); in_valid = 1; in_inst = 32'h0050_0093; in_pc = 32'h12C;
    cyc(); out_ready = 0; rst = 1; flush = 1;
    cyc(); rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk_zero("midrst");

    // randomized traffic, registers restricted to x0..x3 to provoke hazards
    repeat (3000) begin
      cyc();
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      in_inst[6:0]   = ops[$urandom_range(0, 10)];
      in_inst[11:7]  = 5'($urandom_range(0, 3));
      in_inst[19:15] = 5'($urandom_range(0, 3));
      in_inst[24:20] = 5'($urandom_range(0, 3));
      ex_wreg   = $urandom_range(0, 1);
      ex_wd     = 5'($urandom_range(0, 3));
      ex_wdata  = $urandom;
      mem_wreg  = $urandom_range(0, 1);
      mem_wd    = 5'($urandom_range(0, 3));
      mem_wdata = $urandom;
    end

    cyc(); rst = 0; flush = 0; in_valid = 0; out_ready = 1; ex_wreg = 0; mem_wreg = 0;
    repeat (3) cyc();
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
